// File: rtl/arg_regs_avalon.sv
// Avalon-MM argument/command/status register block fronting an accelerator.
// Define ARG_REGS_CYCLE_COUNT_EN to build the RUN-cycle counter at address 2.
module arg_regs_avalon #(
    parameter int unsigned N_ARGIN  = 4,
    parameter int unsigned N_ARGOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    output logic [31:0]              avs_readdata,
    output logic                     avs_readdatavalid,
    output logic                     avs_waitrequest,
    output logic                     accel_enable,
    input  logic                     accel_done,
    output logic [32*N_ARGIN-1:0]    argin_flat,
    input  logic [32*N_ARGOUT-1:0]   argout_flat,
    output logic                     irq
);

    localparam int unsigned DW          = 32;
    localparam int unsigned ARGIN_BASE  = 4;
    localparam int unsigned ARGOUT_BASE = 8;
    localparam logic [3:0]  ADDR_CMD    = 4'd0;
    localparam logic [3:0]  ADDR_STATUS = 4'd1;
`ifdef ARG_REGS_CYCLE_COUNT_EN
    localparam logic [3:0]  ADDR_CYCLES = 4'd2;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N_ARGIN-1:0][DW-1:0]  argin_q;
    logic [N_ARGOUT-1:0][DW-1:0] argout_q;
    logic                        done_q;
    logic                        err_q;
    logic [DW-1:0]               rd_data_c;

    // Register-access decode
    logic wr_cmd_c;
    logic wr_status_c;
    logic wr_argin_c;
    logic cmd_start_c;
    logic cmd_abort_c;

    // Control strobes from the FSM output process
    logic capture_c;
    logic set_done_c;
    logic clr_done_c;
    logic set_err_c;
    logic clr_err_c;

    assign wr_cmd_c    = avs_write && (avs_address == ADDR_CMD);
    assign wr_status_c = avs_write && (avs_address == ADDR_STATUS);
    assign wr_argin_c  = avs_write && (avs_address >= 4'(ARGIN_BASE))
                         && (avs_address < 4'(ARGIN_BASE + N_ARGIN));
    assign cmd_start_c = wr_cmd_c && avs_writedata[0];
    assign cmd_abort_c = wr_cmd_c && avs_writedata[1];

    assign avs_waitrequest = 1'b0;
    assign irq             = done_q;
    assign argin_flat      = argin_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; abort in RUN takes precedence over a completion pulse
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_start_c) state_nxt = RUN;
            end
            RUN: begin
                if (cmd_abort_c)     state_nxt = IDLE;
                else if (accel_done) state_nxt = DONE;
            end
            DONE: begin
                if (cmd_start_c)                             state_nxt = RUN;
                else if (wr_status_c && avs_writedata[1])    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output strobes
    always_comb begin
        capture_c  = 1'b0;
        set_done_c = 1'b0;
        clr_done_c = 1'b0;
        set_err_c  = 1'b0;
        clr_err_c  = wr_status_c && avs_writedata[2];
        case (state)
            RUN: begin
                set_err_c  = cmd_start_c || wr_argin_c;
                capture_c  = accel_done && !cmd_abort_c;
                set_done_c = accel_done && !cmd_abort_c;
            end
            default: begin
                clr_done_c = cmd_start_c;
            end
        endcase
        if (wr_status_c && avs_writedata[1]) clr_done_c = 1'b1;
    end

    // Status flags and run enable; a done set beats a coincident clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            accel_enable <= 1'b0;
        end else begin
            accel_enable <= (state_nxt == RUN);
            if (set_done_c)      done_q <= 1'b1;
            else if (clr_done_c) done_q <= 1'b0;
            if (set_err_c)       err_q  <= 1'b1;
            else if (clr_err_c)  err_q  <= 1'b0;
        end
    end

    // ArgIn registers are writable only outside RUN; ArgOut captured on completion
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            argin_q  <= '0;
            argout_q <= '0;
        end else begin
            if (wr_argin_c && (state != RUN)) begin
                for (int i = 0; i < N_ARGIN; i++) begin
                    if (avs_address == 4'(ARGIN_BASE + i)) argin_q[i] <= avs_writedata;
                end
            end
            if (capture_c) argout_q <= argout_flat;
        end
    end

`ifdef ARG_REGS_CYCLE_COUNT_EN
    logic [DW-1:0] cycles_q;

    // Saturating RUN-cycle counter, restarted on each entry to RUN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycles_q <= '0;
        end else if ((state != RUN) && (state_nxt == RUN)) begin
            cycles_q <= '0;
        end else if ((state == RUN) && (cycles_q != '1)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
`endif

    // Read mux over current (pre-write) register values
    always_comb begin
        rd_data_c = '0;
        case (avs_address)
            ADDR_STATUS: rd_data_c = {29'b0, err_q, done_q, (state == RUN)};
`ifdef ARG_REGS_CYCLE_COUNT_EN
            ADDR_CYCLES: rd_data_c = cycles_q;
`endif
            default: rd_data_c = '0;
        endcase
        for (int i = 0; i < N_ARGIN; i++) begin
            if (avs_address == 4'(ARGIN_BASE + i)) rd_data_c = argin_q[i];
        end
        for (int i = 0; i < N_ARGOUT; i++) begin
            if (avs_address == 4'(ARGOUT_BASE + i)) rd_data_c = argout_q[i];
        end
    end

    // Fixed one-cycle read response
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_arg_regs_avalon.sv
// Directed bench for arg_regs_avalon: read responses go through a scoreboard queue
// checked by an independent monitor; side-band outputs are checked inline.
module tb_arg_regs_avalon;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   avs_address;
    logic         avs_read;
    logic         avs_write;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic         avs_waitrequest;
    logic         accel_enable;
    logic         accel_done;
    logic [127:0] argin_flat;
    logic [127:0] argout_flat;
    logic         irq;

    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  exp_q[$];
    string        name_q[$];
    logic         rd_prev = 1'b0;

`ifdef ARG_REGS_CYCLE_COUNT_EN
    localparam logic [31:0] EXP_CYCLES = 32'd10;
`else
    localparam logic [31:0] EXP_CYCLES = 32'd0;
`endif

    arg_regs_avalon #(.N_ARGIN(4), .N_ARGOUT(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest  (avs_waitrequest),
        .accel_enable     (accel_enable),
        .accel_done       (accel_done),
        .argin_flat       (argin_flat),
        .argout_flat      (argout_flat),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_prev <= avs_read && reset_n;

    // Monitor: checks response timing and pops expected read data
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (avs_readdatavalid !== rd_prev) begin
                n_vec++;
                n_err++;
                $display("FAIL rdv_latency: readdatavalid=%b required=%b", avs_readdatavalid, rd_prev);
            end
            if (avs_readdatavalid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_rdv: readdata=0x%08h with no read pending", avs_readdata);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (avs_readdata !== e) begin
                        n_err++;
                        $display("FAIL %s: readdata=0x%08h required=0x%08h", n, avs_readdata, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick();
        avs_read    = 1'b0;
    endtask

    task automatic rdwr(input string name, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        avs_address   = a;
        avs_writedata = d;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick();
        avs_read      = 1'b0;
        avs_write     = 1'b0;
    endtask

    initial begin
        int en_cnt;
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        accel_done    = 1'b0;
        argout_flat   = {32'h44444444, 32'h33333333, 32'h11111111, 32'hCAFEF00D};
        tick();
        tick();
        check("rst_enable", 32'(accel_enable), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_argin", argin_flat[31:0], 32'd0);
        check("waitrequest", 32'(avs_waitrequest), 32'd0);
        reset_n = 1'b1;
        tick();

        rd("status_idle", 4'd1, 32'h0);
        rd("argin0_rst", 4'd4, 32'h0);
        rd("reserved3", 4'd3, 32'h0);
        rd("cycles_rst", 4'd2, 32'h0);

        // ArgIn write/read, unmapped write ignored, read-during-write returns old value
        wr(4'd4, 32'h12345678);
        check("argin0_flat", argin_flat[31:0], 32'h12345678);
        rd("argin0_rd", 4'd4, 32'h12345678);
        wr(4'd5, 32'hA5A5A5A5);
        wr(4'd12, 32'hDEADBEEF);
        rd("unmapped12", 4'd12, 32'h0);
        rdwr("rdwr_argin2_old", 4'd6, 32'h00000066, 32'h0);
        rd("argin2_new", 4'd6, 32'h00000066);
        check("argin2_flat", argin_flat[95:64], 32'h00000066);

        // Start, run exactly ten cycles, complete with capture
        wr(4'd0, 32'h1);
        en_cnt = 32'(accel_enable);
        for (int i = 0; i < 9; i++) begin
            tick();
            en_cnt += 32'(accel_enable);
        end
        accel_done = 1'b1;
        tick();
        accel_done = 1'b0;
        en_cnt += 32'(accel_enable);
        check("enable_cycles", 32'(en_cnt), 32'd10);
        check("done_irq", 32'(irq), 32'd1);
        rd("argout0_cap", 4'd8, 32'hCAFEF00D);
        rd("argout1_cap", 4'd9, 32'h11111111);
        rd("status_done", 4'd1, 32'h2);
        rd("cycles_run", 4'd2, EXP_CYCLES);

        // Clear done alongside a spurious completion pulse: pulse ignored
        argout_flat[31:0] = 32'h0BADBEEF;
        rd("argout0_hold", 4'd8, 32'hCAFEF00D);
        accel_done = 1'b1;
        wr(4'd1, 32'h2);
        accel_done = 1'b0;
        check("clr_irq", 32'(irq), 32'd0);
        rd("status_cleared", 4'd1, 32'h0);
        rd("argout0_nocap", 4'd8, 32'hCAFEF00D);

        // Writes in RUN are rejected and flag err
        wr(4'd0, 32'h1);
        wr(4'd5, 32'h0000FFFF);
        wr(4'd0, 32'h1);
        check("run_enable", 32'(accel_enable), 32'd1);
        check("argin1_flat_kept", argin_flat[63:32], 32'hA5A5A5A5);
        rd("argin1_kept", 4'd5, 32'hA5A5A5A5);
        rd("status_run_err", 4'd1, 32'h5);

        // Completion coincident with a done-clear: set wins
        accel_done = 1'b1;
        wr(4'd1, 32'h2);
        accel_done = 1'b0;
        check("set_wins_irq", 32'(irq), 32'd1);
        rd("status_set_wins", 4'd1, 32'h6);
        rd("argout0_cap2", 4'd8, 32'h0BADBEEF);
        wr(4'd1, 32'h4);
        rd("status_err_clr", 4'd1, 32'h2);
        rdwr("rdwr_status_old", 4'd1, 32'h2, 32'h2);
        rd("status_idle2", 4'd1, 32'h0);

        // Abort returns to IDLE without capture or done
        wr(4'd0, 32'h1);
        argout_flat[31:0] = 32'h77777777;
        accel_done = 1'b1;
        wr(4'd0, 32'h2);
        accel_done = 1'b0;
        check("abort_enable", 32'(accel_enable), 32'd0);
        rd("status_abort", 4'd1, 32'h0);
        rd("argout0_abort", 4'd8, 32'h0BADBEEF);

        // Reset mid-RUN with a coincident completion pulse
        wr(4'd0, 32'h1);
        check("run2_enable", 32'(accel_enable), 32'd1);
        reset_n    = 1'b0;
        accel_done = 1'b1;
        tick();
        reset_n    = 1'b1;
        accel_done = 1'b0;
        check("rst_run_enable", 32'(accel_enable), 32'd0);
        check("rst_run_irq", 32'(irq), 32'd0);
        check("rst_run_argin", argin_flat[31:0], 32'd0);
        rd("status_after_rst", 4'd1, 32'h0);
        rd("argout0_after_rst", 4'd8, 32'h0);
        rd("cycles_after_rst", 4'd2, 32'h0);

        tick();
        tick();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pending_reads: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arg_regs_avalon.md
ARG_REGS_AVALON -- requirements
Module: arg_regs_avalon

Interface
REQ-001 Parameter N_ARGIN, default 4, number of 32-bit ArgIn registers (legal 1..4).
REQ-002 Parameter N_ARGOUT, default 4, number of 32-bit ArgOut registers (legal 1..4).
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- avs_address  in  4  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data qualifier
- avs_waitrequest  out  1  constant 0
- accel_enable  out  1  accelerator run enable
- accel_done  in  1  one-cycle completion pulse from accelerator
- argin_flat  out  32*N_ARGIN  ArgIn values; ArgIn k at bits [32k+31:32k]
- argout_flat  in  32*N_ARGOUT  accelerator ArgOut values, same packing
- irq  out  1  level interrupt, equal to STATUS.done

Function
REQ-010 Address map SHALL be: 0 CMD (W), 1 STATUS (R/W1C), 2 CYCLES (R), 3 reserved (reads 0), 4..4+N_ARGIN-1 ArgIn (R/W), 8..8+N_ARGOUT-1 ArgOut (R); unmapped addresses read 0, writes ignored.
REQ-011 Reads SHALL have a fixed latency of 1: avs_readdatavalid high exactly one cycle after each avs_read cycle, carrying data sampled in the avs_read cycle.
REQ-012 If avs_read and avs_write are both asserted, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; accel_enable high only in RUN.
REQ-014 Writing CMD with bit0=1 in IDLE or DONE SHALL move to RUN on the next edge and clear STATUS.done.
REQ-015 In RUN, accel_done SHALL move to DONE, capture all argout_flat into ArgOut registers in the same edge, and set STATUS.done.
REQ-016 accel_done in IDLE or DONE SHALL be ignored (no capture, no state change).
REQ-017 CMD start while in RUN SHALL be ignored and set STATUS.err (sticky).
REQ-018 ArgIn writes while in RUN SHALL be dropped and set STATUS.err; ArgIn writes in IDLE/DONE update the register on the next edge.
REQ-019 STATUS read SHALL return {29'b0, err, done, busy}; busy = (state==RUN).
REQ-020 Writing STATUS with bit1=1 clears done and returns DONE to IDLE; bit2=1 clears err; if accel_done and a done-clear coincide, set SHALL win.
REQ-021 CMD bit1=1 (abort) in RUN SHALL return to IDLE next edge without setting done or capturing ArgOuts.
REQ-022 avs_waitrequest SHALL be constant 0.

Reset
REQ-030 On a clock edge with reset_n low: state=IDLE; all ArgIn, ArgOut, CYCLES, done, err = 0; accel_enable, avs_readdatavalid, irq = 0; avs_readdata = 0.
REQ-031 Reset asserted in RUN SHALL drop accel_enable at that edge; an accel_done in the same cycle SHALL be ignored.

Configuration
REQ-040 Macro ARG_REGS_CYCLE_COUNT_EN: when defined, CYCLES is a 32-bit counter cleared on entry to RUN, incremented each RUN cycle, saturating at 0xFFFFFFFF, holding in IDLE/DONE.
REQ-041 When ARG_REGS_CYCLE_COUNT_EN is undefined, no counter is built and address 2 reads 0.

Verification
REQ-050 Write ArgIn0=0x12345678, read addr 4 -> readdatavalid one cycle later with 0x12345678; argin_flat[31:0]=0x12345678.
REQ-051 Write CMD=1, hold argout_flat[31:0]=0xCAFEF00D, pulse accel_done after 10 cycles -> accel_enable high 10 cycles, addr 8 reads 0xCAFEF00D, STATUS=0x2, irq=1; CYCLES=10 with macro, 0 without.
REQ-052 In RUN write ArgIn1=0xFFFF and CMD=1 -> ArgIn1 unchanged, state stays RUN, STATUS=0x5.
REQ-053 In DONE, write STATUS=0x2 in the same cycle as a spurious accel_done -> done cleared, state IDLE (ignored pulse); in RUN, accel_done coincident with STATUS write 0x2 -> STATUS.done=1.
REQ-054 Assert reset_n low for one cycle mid-RUN with accel_done high -> accel_enable=0, STATUS=0x0, ArgOut0 reads 0.
REQ-055 Write CMD=0x2 during RUN -> IDLE, STATUS=0x0, ArgOut registers unchanged from prior values.
